// File: rtl/sync_pkt_sched.sv
// sync_pkt_sched: turns delayed hsync/vsync pulses into a CSI-2 packet request
// stream (Frame Start, one long packet per active line, Frame End). Requests use
// a req/ack handshake. Pulses that arrive while a request is stalled are queued.
module sync_pkt_sched #(
  parameter int          V_ACTIVE      = 720,
  parameter int          LINE_BYTES    = 1280,
  parameter logic [5:0]  DATA_TYPE     = 6'h2A,
  parameter logic [15:0] FRAME_NUM_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hsync_dly,
  input  logic        vsync_dly,
  output logic        pkt_req,
  input  logic        pkt_ack,
  output logic [5:0]  pkt_dt,
  output logic [15:0] pkt_wc,
  output logic        pkt_long,
  output logic [15:0] frame_num,
  output logic [15:0] line_cnt,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_trunc,
  input  logic        err_clr
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FS_REQ    = 3'd1;
  localparam logic [2:0] WAIT_LINE = 3'd2;
  localparam logic [2:0] LINE_REQ  = 3'd3;
  localparam logic [2:0] FE_REQ    = 3'd4;

  localparam logic [15:0] LAST_LINE = 16'(V_ACTIVE);
  localparam logic [15:0] LINE_WC   = 16'(LINE_BYTES);
  localparam logic [5:0]  DT_FS     = 6'h00;
  localparam logic [5:0]  DT_FE     = 6'h01;

  logic [2:0]  state;
  logic        hs_pend;
  logic        vs_pend;
  logic        accept;
  logic        ovf_evt;
  logic        trunc_evt;
  logic [15:0] line_next;
  logic [15:0] frame_next;

  assign accept     = pkt_req & pkt_ack;
  assign busy       = (state != IDLE);
  assign line_next  = line_cnt + 16'd1;
  assign frame_next = (frame_num == FRAME_NUM_MAX) ? 16'd1 : frame_num + 16'd1;

  // A truncating vsync wipes the line queue, so a coincident hsync is not an overflow.
  assign trunc_evt = vsync_dly & ((state == WAIT_LINE) | (state == LINE_REQ));
  assign ovf_evt   = hsync_dly & hs_pend &
                     ((state == FS_REQ) | ((state == LINE_REQ) & ~vsync_dly));

  // Packet scheduling FSM: registered request fields, pending pulse flags and counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      hs_pend   <= 1'b0;
      vs_pend   <= 1'b0;
      pkt_req   <= 1'b0;
      pkt_dt    <= 6'd0;
      pkt_wc    <= 16'd0;
      pkt_long  <= 1'b0;
      frame_num <= 16'd1;
      line_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (vsync_dly || vs_pend) begin
            state    <= FS_REQ;
            pkt_req  <= 1'b1;
            pkt_dt   <= DT_FS;
            pkt_wc   <= frame_num;
            pkt_long <= 1'b0;
            hs_pend  <= hsync_dly & vsync_dly;
          end else begin
            hs_pend  <= 1'b0;
          end
        end
        FS_REQ: begin
          if (hsync_dly) hs_pend <= 1'b1;
          if (accept) begin
            pkt_req  <= 1'b0;
            line_cnt <= 16'd0;
            vs_pend  <= vsync_dly;
            state    <= WAIT_LINE;
          end else if (vsync_dly) begin
            vs_pend  <= 1'b1;
          end
        end
        WAIT_LINE: begin
          if (vsync_dly || vs_pend) begin
            state    <= FE_REQ;
            pkt_req  <= 1'b1;
            pkt_dt   <= DT_FE;
            pkt_wc   <= frame_num;
            pkt_long <= 1'b0;
            vs_pend  <= 1'b1;
            hs_pend  <= 1'b0;
          end else if (hsync_dly || hs_pend) begin
            state    <= LINE_REQ;
            pkt_req  <= 1'b1;
            pkt_dt   <= DATA_TYPE;
            pkt_wc   <= LINE_WC;
            pkt_long <= 1'b1;
            hs_pend  <= hsync_dly & hs_pend;
          end
        end
        LINE_REQ: begin
          if (vsync_dly) begin
            vs_pend <= 1'b1;
            hs_pend <= 1'b0;
          end else if (hsync_dly) begin
            hs_pend <= 1'b1;
          end
          if (accept) begin
            pkt_req  <= 1'b0;
            line_cnt <= line_next;
            if (vsync_dly || vs_pend || (line_next == LAST_LINE)) begin
              state    <= FE_REQ;
              pkt_dt   <= DT_FE;
              pkt_wc   <= frame_num;
              pkt_long <= 1'b0;
              hs_pend  <= 1'b0;
            end else begin
              state    <= WAIT_LINE;
            end
          end
        end
        FE_REQ: begin
          hs_pend <= 1'b0;
          if (vsync_dly) vs_pend <= 1'b1;
          if (accept) begin
            pkt_req   <= 1'b0;
            frame_num <= frame_next;
            state     <= IDLE;
          end else if (!pkt_req) begin
            pkt_req   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky sync errors; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf   <= 1'b0;
      err_trunc <= 1'b0;
    end else begin
      err_ovf   <= ovf_evt   | (err_ovf   & ~err_clr);
      err_trunc <= trunc_evt | (err_trunc & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sync_pkt_sched.sv
// tb_sync_pkt_sched: directed scoreboard bench. Stimulus pushes the expected
// packets; a monitor pops and compares on every accepted request.
module tb_sync_pkt_sched;

  logic        clk;
  logic        rstn;
  logic        hsync_dly;
  logic        vsync_dly;
  logic        pkt_req;
  logic        pkt_ack;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic        pkt_long;
  logic [15:0] frame_num;
  logic [15:0] line_cnt;
  logic        busy;
  logic        err_ovf;
  logic        err_trunc;
  logic        err_clr;

  int tests_run = 0;
  int tests_failed = 0;
  int stall_cycles = 0;
  bit req_seen = 1'b0;

  logic [22:0] sb[$];

  sync_pkt_sched #(
    .V_ACTIVE(3),
    .LINE_BYTES(1280),
    .DATA_TYPE(6'h2A),
    .FRAME_NUM_MAX(16'd2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .hsync_dly(hsync_dly),
    .vsync_dly(vsync_dly),
    .pkt_req(pkt_req),
    .pkt_ack(pkt_ack),
    .pkt_dt(pkt_dt),
    .pkt_wc(pkt_wc),
    .pkt_long(pkt_long),
    .frame_num(frame_num),
    .line_cnt(line_cnt),
    .busy(busy),
    .err_ovf(err_ovf),
    .err_trunc(err_trunc),
    .err_clr(err_clr)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [22:0] pkt(input logic [5:0] dt, input logic [15:0] wc, input logic lng);
    return {dt, wc, lng};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Acknowledge generator: ack tied high, or raised after a stall of stall_cycles.
  initial begin
    int cnt;
    cnt = 0;
    pkt_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cycles == 0) begin
        pkt_ack = 1'b1;
      end else if (pkt_req && !pkt_ack) begin
        cnt++;
        if (cnt >= stall_cycles) pkt_ack = 1'b1;
      end else begin
        pkt_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops on acceptance, checks field stability and the post-accept gap.
  initial begin
    logic [22:0] cur;
    logic [22:0] held;
    logic [22:0] exp_pkt;
    bit hold_valid;
    bit need_low;
    hold_valid = 1'b0;
    need_low = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {pkt_dt, pkt_wc, pkt_long};
      if (pkt_req) req_seen = 1'b1;
      if (need_low) begin
        checkOutput("req_low_after_accept", {31'd0, pkt_req}, 32'd0);
        need_low = 1'b0;
      end
      if (pkt_req && hold_valid)
        checkOutput("fields_stable", {9'd0, cur}, {9'd0, held});
      if (pkt_req && pkt_ack) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_pkt: got dt=0x%0h wc=%0d long=%0d, expected none",
                   pkt_dt, pkt_wc, pkt_long);
        end else begin
          exp_pkt = sb.pop_front();
          checkOutput("pkt_fields", {9'd0, cur}, {9'd0, exp_pkt});
        end
        hold_valid = 1'b0;
        need_low = 1'b1;
      end else begin
        hold_valid = pkt_req;
        held = cur;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic vs, input logic hs);
    @(posedge clk);
    #1;
    vsync_dly = vs;
    hsync_dly = hs;
    @(posedge clk);
    #1;
    vsync_dly = 1'b0;
    hsync_dly = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    hsync_dly = 1'b0;
    vsync_dly = 1'b0;
    err_clr = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || pkt_req) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_drained"}, sb.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [15:0] f);
    sb.push_back(pkt(6'h00, f, 1'b0));
    repeat (3) sb.push_back(pkt(6'h2A, 16'd1280, 1'b1));
    sb.push_back(pkt(6'h01, f, 1'b0));
  endtask

  task automatic run_frame(input int gap);
    applyStimulus(1'b1, 1'b1);
    repeat (gap) @(posedge clk);
    applyStimulus(1'b0, 1'b1);
    repeat (gap) @(posedge clk);
    applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    rstn = 1'b0;
    hsync_dly = 1'b0;
    vsync_dly = 1'b0;
    err_clr = 1'b0;

    // Reset values and blanking hsyncs in IDLE
    stall_cycles = 0;
    do_reset();
    checkOutput("rst_req", {31'd0, pkt_req}, 32'd0);
    checkOutput("rst_frame_num", {16'd0, frame_num}, 32'd1);
    checkOutput("rst_line_cnt", {16'd0, line_cnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_errs", {30'd0, err_ovf, err_trunc}, 32'd0);
    checkOutput("rst_fields", {9'd0, pkt_dt, pkt_wc, pkt_long}, 32'd0);
    req_seen = 1'b0;
    repeat (3) begin
      applyStimulus(1'b0, 1'b1);
      repeat (4) @(posedge clk);
    end
    checkOutput("idle_hs_no_req", {31'd0, req_seen}, 32'd0);
    checkOutput("idle_hs_busy", {31'd0, busy}, 32'd0);

    // Full frame with ack tied high
    do_reset();
    push_frame(16'd1);
    run_frame(50);
    wait_drain("frame1", 200);
    checkOutput("f1_frame_num", {16'd0, frame_num}, 32'd2);
    checkOutput("f1_line_cnt", {16'd0, line_cnt}, 32'd3);
    checkOutput("f1_busy", {31'd0, busy}, 32'd0);
    checkOutput("f1_errs", {30'd0, err_ovf, err_trunc}, 32'd0);
    applyStimulus(1'b0, 1'b1);
    repeat (4) @(posedge clk);
    checkOutput("extra_hs_busy", {31'd0, busy}, 32'd0);
    checkOutput("extra_hs_errs", {30'd0, err_ovf, err_trunc}, 32'd0);

    // Stalled ack: second hsync during the FS stall overflows, one line is served
    do_reset();
    stall_cycles = 100;
    sb.push_back(pkt(6'h00, 16'd1, 1'b0));
    sb.push_back(pkt(6'h2A, 16'd1280, 1'b1));
    applyStimulus(1'b1, 1'b1);
    repeat (20) @(posedge clk);
    applyStimulus(1'b0, 1'b1);
    wait_drain("ovf", 400);
    checkOutput("ovf_err_ovf", {31'd0, err_ovf}, 32'd1);
    checkOutput("ovf_err_trunc", {31'd0, err_trunc}, 32'd0);
    checkOutput("ovf_line_cnt", {16'd0, line_cnt}, 32'd1);
    checkOutput("ovf_busy", {31'd0, busy}, 32'd1);
    pulse_clr();
    checkOutput("ovf_cleared", {31'd0, err_ovf}, 32'd0);

    // Truncating vsync after 1 of 3 lines: FE(1) then automatic FS(2)
    sb.push_back(pkt(6'h01, 16'd1, 1'b0));
    sb.push_back(pkt(6'h00, 16'd2, 1'b0));
    applyStimulus(1'b1, 1'b0);
    wait_drain("trunc", 400);
    checkOutput("trunc_err", {31'd0, err_trunc}, 32'd1);
    checkOutput("trunc_frame_num", {16'd0, frame_num}, 32'd2);
    checkOutput("trunc_line_cnt", {16'd0, line_cnt}, 32'd0);
    checkOutput("trunc_busy", {31'd0, busy}, 32'd1);
    pulse_clr();
    checkOutput("trunc_cleared", {30'd0, err_ovf, err_trunc}, 32'd0);
    stall_cycles = 0;

    // Frame number wrap with FRAME_NUM_MAX=2: 1,2,1
    do_reset();
    push_frame(16'd1);
    run_frame(10);
    wait_drain("wrap1", 100);
    checkOutput("wrap1_frame_num", {16'd0, frame_num}, 32'd2);
    push_frame(16'd2);
    run_frame(10);
    wait_drain("wrap2", 100);
    checkOutput("wrap2_frame_num", {16'd0, frame_num}, 32'd1);
    push_frame(16'd1);
    run_frame(10);
    wait_drain("wrap3", 100);
    checkOutput("wrap3_frame_num", {16'd0, frame_num}, 32'd2);
    checkOutput("wrap3_line_cnt", {16'd0, line_cnt}, 32'd3);

    // Reset while a line request is stalled, then a clean frame
    do_reset();
    stall_cycles = 30;
    sb.push_back(pkt(6'h00, 16'd1, 1'b0));
    applyStimulus(1'b1, 1'b1);
    begin
      int n;
      n = 0;
      while (!(pkt_req && pkt_long) && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("midrst_line_req_seen", {31'd0, pkt_req & pkt_long}, 32'd1);
    end
    repeat (5) @(posedge clk);
    checkOutput("midrst_line_cnt", {16'd0, line_cnt}, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst_req", {31'd0, pkt_req}, 32'd0);
    checkOutput("midrst_frame_num", {16'd0, frame_num}, 32'd1);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_sb_empty", sb.size(), 32'd0);
    stall_cycles = 0;
    do_reset();
    push_frame(16'd1);
    run_frame(10);
    wait_drain("postrst", 100);
    checkOutput("postrst_frame_num", {16'd0, frame_num}, 32'd2);
    checkOutput("postrst_errs", {30'd0, err_ovf, err_trunc}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
